// File: rtl/alu_req_arbiter.sv
// Four-requester round-robin arbiter for a serial-command ALU: latches the winner's operands,
// issues A/B/GO on the command bus, waits for completion and returns a one-cycle response.
// Optional WAIT timeout: define ALU_ARB_TIMEOUT_EN.
module alu_req_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              req,
  input  logic [7:0]              req_opcode,
  input  logic [4*DATA_WIDTH-1:0] req_a,
  input  logic [4*DATA_WIDTH-1:0] req_b,
  output logic [3:0]              grant,
  output logic                    busy,
  output logic                    resp_valid,
  output logic [1:0]              resp_id,
  output logic [DATA_WIDTH-1:0]   resp_result,
  output logic                    resp_overflow,
  output logic                    resp_error,
  output logic                    alu_opcode_valid,
  output logic                    alu_opcode,
  output logic [DATA_WIDTH-1:0]   alu_data,
  input  logic                    alu_done,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_overflow
);

  typedef enum logic [2:0] {
    StIdle,
    StIssueA,
    StIssueB,
    StIssueGo,
    StWait,
    StResp
  } state_e;

  state_e                  state_q;
  logic [1:0]              last_q;
  logic                    op_b_q;
  logic [DATA_WIDTH-1:0]   b_q;

  logic                    win_found;
  logic [1:0]              win_idx;
  logic [1:0]              cand;
  logic [1:0]              win_op;
  logic [DATA_WIDTH-1:0]   win_a;
  logic [DATA_WIDTH-1:0]   win_b;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  assign resp_error = err_q;
`else
  assign resp_error = 1'b0;
`endif

  // Round-robin search starting just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_op = req_opcode[2*int'(win_idx) +: 2];
  assign win_a  = req_a[DATA_WIDTH*int'(win_idx) +: DATA_WIDTH];
  assign win_b  = req_b[DATA_WIDTH*int'(win_idx) +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      last_q           <= 2'd3;
      op_b_q           <= 1'b0;
      b_q              <= '0;
      grant            <= 4'b0;
      busy             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_id          <= 2'd0;
      resp_result      <= '0;
      resp_overflow    <= 1'b0;
      alu_opcode_valid <= 1'b0;
      alu_opcode       <= 1'b0;
      alu_data         <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q            <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q          <= StIssueA;
            last_q           <= win_idx;
            grant            <= 4'b0001 << win_idx;
            busy             <= 1'b1;
            op_b_q           <= win_op[1];
            b_q              <= win_b;
            // Operand A goes straight onto the bus; it is never needed again.
            alu_opcode_valid <= 1'b1;
            alu_opcode       <= win_op[0];
            alu_data         <= win_a;
          end
        end
        StIssueA: begin
          state_q    <= StIssueB;
          alu_opcode <= op_b_q;
          alu_data   <= b_q;
        end
        StIssueB: begin
          state_q    <= StIssueGo;
          alu_opcode <= 1'b0;
          alu_data   <= '0;
        end
        StIssueGo: begin
          state_q          <= StWait;
          alu_opcode_valid <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_q            <= '0;
`endif
        end
        StWait: begin
          if (alu_done) begin
            state_q       <= StResp;
            resp_valid    <= 1'b1;
            resp_id       <= last_q;
            resp_result   <= alu_result;
            resp_overflow <= alu_overflow;
`ifdef ALU_ARB_TIMEOUT_EN
            err_q         <= 1'b0;
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_q       <= StResp;
            resp_valid    <= 1'b1;
            resp_id       <= last_q;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            err_q         <= 1'b1;
          end else begin
            cnt_q         <= cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
          state_q       <= StIdle;
          grant         <= 4'b0;
          busy          <= 1'b0;
          resp_valid    <= 1'b0;
          resp_id       <= 2'd0;
          resp_result   <= '0;
          resp_overflow <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
          err_q         <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed vector table, reset/timeout sequences and
// randomized transactions checked against a round-robin reference model.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [3:0]  grant;
  logic        busy, resp_valid, resp_overflow, resp_error;
  logic [1:0]  resp_id;
  logic [7:0]  resp_result;
  logic        alu_opcode_valid, alu_opcode;
  logic [7:0]  alu_data;
  logic        alu_done, alu_overflow;
  logic [7:0]  alu_result;

  alu_req_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .req_opcode       (req_opcode),
    .req_a            (req_a),
    .req_b            (req_b),
    .grant            (grant),
    .busy             (busy),
    .resp_valid       (resp_valid),
    .resp_id          (resp_id),
    .resp_result      (resp_result),
    .resp_overflow    (resp_overflow),
    .resp_error       (resp_error),
    .alu_opcode_valid (alu_opcode_valid),
    .alu_opcode       (alu_opcode),
    .alu_data         (alu_data),
    .alu_done         (alu_done),
    .alu_result       (alu_result),
    .alu_overflow     (alu_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int last_win = 3;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [7:0]  res;
    logic        ovf;
    bit          scramble;
    int          exp_id;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_grant"}, 32'(grant), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({name, "_resp_result"}, 32'(resp_result), 32'd0);
    chk({name, "_resp_ovf"}, 32'(resp_overflow), 32'd0);
    chk({name, "_resp_err"}, 32'(resp_error), 32'd0);
    chk({name, "_alu_valid"}, 32'(alu_opcode_valid), 32'd0);
    chk({name, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    chk({name, "_alu_data"}, 32'(alu_data), 32'd0);
  endtask

  // Reference: first requesting index after the previous winner, wrapping mod 4.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic run_txn(input vec_t v, input int exp_id);
    logic [7:0]  ea, eb;
    logic [1:0]  eop;
    logic [31:0] eg;
    ea  = v.a[exp_id*8 +: 8];
    eb  = v.b[exp_id*8 +: 8];
    eop = v.op[exp_id*2 +: 2];
    eg  = 32'd1 << exp_id;
    req = v.req; req_opcode = v.op; req_a = v.a; req_b = v.b;
    step();
    chk("issue_a_grant", 32'(grant), eg);
    chk("issue_a_busy", 32'(busy), 32'd1);
    chk("issue_a_valid", 32'(alu_opcode_valid), 32'd1);
    chk("issue_a_opcode", 32'(alu_opcode), 32'(eop[0]));
    chk("issue_a_data", 32'(alu_data), 32'(ea));
    if (v.scramble) begin
      req = 4'b0; req_a = ~v.a; req_b = ~v.b; req_opcode = ~v.op;
    end
    // Completion strobes outside WAIT must have no effect.
    alu_done = 1'b1; alu_result = 8'hEE; alu_overflow = 1'b1;
    step();
    chk("issue_b_grant", 32'(grant), eg);
    chk("issue_b_valid", 32'(alu_opcode_valid), 32'd1);
    chk("issue_b_opcode", 32'(alu_opcode), 32'(eop[1]));
    chk("issue_b_data", 32'(alu_data), 32'(eb));
    step();
    chk("issue_go_valid", 32'(alu_opcode_valid), 32'd1);
    chk("issue_go_opcode", 32'(alu_opcode), 32'd0);
    chk("issue_go_data", 32'(alu_data), 32'd0);
    chk("issue_go_resp", 32'(resp_valid), 32'd0);
    alu_done = 1'b0; alu_result = 8'h00; alu_overflow = 1'b0;
    step();
    chk("wait_valid", 32'(alu_opcode_valid), 32'd0);
    chk("wait_data", 32'(alu_data), 32'd0);
    chk("wait_grant", 32'(grant), eg);
    for (int k = 0; k < v.lat; k++) begin
      chk("wait_resp", 32'(resp_valid), 32'd0);
      step();
    end
    alu_done = 1'b1; alu_result = v.res; alu_overflow = v.ovf;
    step();
    alu_done = 1'b0; alu_result = 8'h00; alu_overflow = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_result", 32'(resp_result), 32'(v.res));
    chk("resp_overflow", 32'(resp_overflow), 32'(v.ovf));
    chk("resp_error", 32'(resp_error), 32'd0);
    chk("resp_grant", 32'(grant), eg);
    chk("resp_busy", 32'(busy), 32'd1);
    step();
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_resp_grant", 32'(grant), 32'd0);
    chk("post_resp_busy", 32'(busy), 32'd0);
    chk("post_resp_result", 32'(resp_result), 32'd0);
    last_win = exp_id;
  endtask

  initial begin
    vec_t rv;
    int   ex;

    tbl[0] = '{4'b0001, 8'h00, 32'h0000_0003, 32'h0000_0004, 0, 8'h07, 1'b0, 1'b0, 0};
    for (int i = 1; i <= 4; i++)
      tbl[i] = '{4'b1111, 8'b11_10_01_00, 32'h4030_2010, 32'h0403_0201, 1,
                 8'(8'h10 + i), 1'(i % 2), 1'b0, i % 4};
    tbl[5] = '{4'b0100, 8'b00_10_00_00, 32'h00AA_0000, 32'h00BB_0000, 2, 8'h5A, 1'b0, 1'b1, 2};
    tbl[6] = '{4'b1010, 8'b01_00_11_00, 32'h9900_7700, 32'h8800_6600, 0, 8'h33, 1'b1, 1'b0, 3};
    tbl[7] = '{4'b1010, 8'b01_00_11_00, 32'h9900_7700, 32'h8800_6600, 0, 8'h44, 1'b0, 1'b0, 1};
    tbl[8] = '{4'b0011, 8'b00_00_10_01, 32'h0000_C1C0, 32'h0000_D1D0, 3, 8'hFF, 1'b1, 1'b0, 0};

    reset_n = 1'b0; req = 4'b0; req_opcode = 8'h0; req_a = 32'h0; req_b = 32'h0;
    alu_done = 1'b0; alu_result = 8'h0; alu_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_quiet("idle");

    // Directed table, back to back from reset.
    for (int i = 0; i < 9; i++) run_txn(tbl[i], tbl[i].exp_id);

    // Reset during WAIT discards the operation and restarts round-robin at requester 0.
    req = 4'b0100; req_opcode = 8'hFF; req_a = 32'h1122_3344; req_b = 32'h5566_7788;
    step();
    chk("rst_seq_grant", 32'(grant), 32'b0100);
    req = 4'b0;
    step(); step(); step();
    chk("rst_seq_in_wait", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    alu_done = 1'b1; alu_result = 8'h99;
    @(posedge clk);
    #1;
    chk("reset_hold_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; alu_done = 1'b0; alu_result = 8'h00;
    last_win = 3;
    run_txn('{4'b1111, 8'h1B, 32'hDEAD_BEEF, 32'h0102_0304, 0, 8'h21, 1'b0, 1'b0, 0}, 0);

    // No completion from the ALU: either timeout or an indefinitely busy arbiter.
    req = 4'b0010; req_opcode = 8'h00; req_a = 32'h0000_1100; req_b = 32'h0000_2200;
    step();
    chk("stall_grant", 32'(grant), 32'b0010);
    req = 4'b0;
    alu_result = 8'hAB; alu_overflow = 1'b1;
    step(); step(); step();
`ifdef ALU_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk("timeout_early_resp", 32'(resp_valid), 32'd0);
      step();
    end
    chk("timeout_resp_valid", 32'(resp_valid), 32'd1);
    chk("timeout_resp_error", 32'(resp_error), 32'd1);
    chk("timeout_resp_result", 32'(resp_result), 32'd0);
    chk("timeout_resp_ovf", 32'(resp_overflow), 32'd0);
    chk("timeout_resp_id", 32'(resp_id), 32'd1);
    step();
    chk("timeout_idle_busy", 32'(busy), 32'd0);
    chk("timeout_idle_err", 32'(resp_error), 32'd0);
    last_win = 1;
`else
    for (int k = 0; k < 40; k++) begin
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_resp", 32'(resp_valid), 32'd0);
      step();
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_quiet("stall_reset");
    @(negedge clk);
    reset_n = 1'b1;
    last_win = 3;
`endif
    alu_result = 8'h00; alu_overflow = 1'b0;

    // Randomized traffic against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      rv.req      = 4'($urandom_range(1, 15));
      rv.op       = 8'($urandom);
      rv.a        = $urandom;
      rv.b        = $urandom;
      rv.lat      = int'($urandom_range(0, 4));
      rv.res      = 8'($urandom);
      rv.ovf      = 1'($urandom);
      rv.scramble = 1'($urandom);
      ex          = rr_pick(rv.req, last_win);
      rv.exp_id   = ex;
      run_txn(rv, ex);
    end

    req = 4'b0;
    step();
    chk("final_idle_busy", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, operand/result width.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, WAIT-state cycle limit when timeout feature compiled in.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  4  per-requester operation request.
REQ-006 Port: req_opcode  in  8  2-bit opcode per requester, requester i at [2i+1:2i]; 00 ADD, 01 SUB, 10 PAR, 11 COMP.
REQ-007 Port: req_a, req_b  in  4*DATA_WIDTH each  operand A/B per requester, requester i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-008 Port: grant  out  4  one-hot owner of the ALU.
REQ-009 Port: busy  out  1  high in any state other than IDLE.
REQ-010 Port: resp_valid  out  1  one-cycle response strobe.
REQ-011 Port: resp_id  out  2  index of responding requester.
REQ-012 Port: resp_result  out  DATA_WIDTH; resp_overflow  out  1; resp_error  out  1.
REQ-013 Port: alu_opcode_valid  out  1; alu_opcode  out  1; alu_data  out  DATA_WIDTH  serial ALU command bus.
REQ-014 Port: alu_done  in  1; alu_result  in  DATA_WIDTH; alu_overflow  in  1  ALU completion and outputs.

Function
REQ-015 States SHALL be IDLE, ISSUE_A, ISSUE_B, ISSUE_GO, WAIT, RESP.
REQ-016 IDLE with any req bit high SHALL select a winner round-robin starting at (last_winner+1) mod 4, latch its opcode/A/B, set grant one-hot, go to ISSUE_A.
REQ-017 grant SHALL stay constant from ISSUE_A through RESP inclusive and go to 0 on RESP exit.
REQ-018 ISSUE_A SHALL drive alu_opcode_valid=1, alu_opcode=opcode[0], alu_data=A for exactly one cycle.
REQ-019 ISSUE_B SHALL drive alu_opcode_valid=1, alu_opcode=opcode[1], alu_data=B for exactly one cycle.
REQ-020 ISSUE_GO SHALL drive alu_opcode_valid=1, alu_opcode=0, alu_data=0 for exactly one cycle, then go to WAIT.
REQ-021 In IDLE, WAIT and RESP alu_opcode_valid, alu_opcode and alu_data SHALL be 0.
REQ-022 WAIT SHALL capture alu_result/alu_overflow on the cycle alu_done is sampled high and go to RESP; alu_done in other states SHALL be ignored.
REQ-023 RESP SHALL assert resp_valid for one cycle with resp_id, captured result/overflow, resp_error=0, then go to IDLE; all resp_* SHALL be 0 outside RESP.
REQ-024 Operands are latched at grant; req or operand changes after grant SHALL NOT affect the running operation, and deasserting req while granted SHALL NOT abort it.
REQ-025 Earliest re-grant is the IDLE cycle following RESP; a requester still asserting req after its RESP competes normally.
REQ-026 Zero-latency ALU (alu_done high on first WAIT cycle) SHALL give resp_valid exactly 5 cycles after leaving IDLE.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, grant=0, busy=0, all resp_* and alu_* outputs 0, latched operands 0, timeout counter 0.
REQ-028 Reset SHALL set last_winner=3 so requester 0 wins first; reset mid-operation SHALL discard it with no resp_valid.

Configuration
REQ-029 Macro ALU_ARB_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYCLES without alu_done go to RESP with resp_error=1, resp_result=0, resp_overflow=0.
REQ-030 Macro ALU_ARB_TIMEOUT_EN undefined: no counter, WAIT indefinite, resp_error tied 0.

Verification
REQ-031 Reset, req=0001, opcode0=00, A=3, B=4, ALU returns done+7 -> alu_data 3,4,0 on successive cycles, resp_valid with id=0, result=7, grant=0001 throughout.
REQ-032 req=1111 held, ALU always completes -> grants in order 0,1,2,3,0, one resp_valid per grant.
REQ-033 Requester 2 drops req and changes A after grant -> operation completes with original operands, resp_id=2.
REQ-034 reset_n pulsed low during WAIT -> all outputs 0 that cycle, no resp_valid, next grant to requester 0.
REQ-035 ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, alu_done never asserted -> resp_valid with resp_error=1, result=0 after 16 WAIT cycles; without macro busy stays 1 indefinitely.
